// File: rtl/mspe_dispatch.sv
// mspe_dispatch: steers each whole 512-bit Avalon-ST packet to one core's sink
// FIFO, chosen round-robin among cores that have room for a maximum-size packet.
// Optional per-core packet counters are built when MSPE_DISPATCH_STATS_EN is defined.
module mspe_dispatch #(
  parameter int CORES         = 4,
  parameter int PKT_MAX_BEATS = 16,
  parameter int SLACK         = 2,
  parameter int FREE_W        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [511:0]              snk_data,
  input  logic                      snk_valid,
  input  logic                      snk_sop,
  input  logic                      snk_eop,
  output logic                      snk_ready,
  output logic [511:0]              dst_data,
  output logic [CORES-1:0]          dst_we,
  output logic                      dst_sop,
  output logic                      dst_eop,
  input  logic [CORES*FREE_W-1:0]   dst_free,
  output logic [3:0]                cur_core,
  output logic                      busy,
`ifdef MSPE_DISPATCH_STATS_EN
  output logic [CORES*32-1:0]       stat_pkts,
`endif
  output logic [15:0]               err_count
);

  localparam int PTR_W = $clog2(CORES);
  localparam int CNT_W = $clog2(PKT_MAX_BEATS + 1);
  localparam logic [FREE_W-1:0] NEED = FREE_W'(PKT_MAX_BEATS + SLACK);
  localparam logic [CORES-1:0]  ONE  = CORES'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [CORES-1:0] eligible;
  logic             any_elig;
  logic             sel_found;
  logic [PTR_W-1:0] sel_core;
  logic [PTR_W-1:0] rr_next;
  logic [PTR_W:0]   scan_sum;
  logic             accept;
  logic             beat_last;
  logic             err_hit;

  // A core may take a new packet only if a full-length packet plus slack fits.
  genvar gi;
  generate
    for (gi = 0; gi < CORES; gi++) begin : g_elig
      assign eligible[gi] = dst_free[gi*FREE_W +: FREE_W] >= NEED;
    end
  endgenerate

  assign any_elig  = |eligible;
  assign accept    = snk_valid & snk_ready;
  assign beat_last = (beat_cnt == CNT_W'(PKT_MAX_BEATS - 1));
  assign busy      = (state != IDLE);

  // Round-robin scan: first eligible core starting at rr_ptr, wrapping mod CORES.
  always_comb begin
    sel_found = 1'b0;
    sel_core  = '0;
    scan_sum  = '0;
    for (int k = 0; k < CORES; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(CORES)) scan_sum = scan_sum - (PTR_W+1)'(CORES);
      if (!sel_found && eligible[scan_sum[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_core  = scan_sum[PTR_W-1:0];
      end
    end
    rr_next = (sel_core == PTR_W'(CORES - 1)) ? '0 : sel_core + 1'b1;
  end

  // Back-pressure only a packet start that has nowhere to go.
  always_comb begin
    snk_ready = 1'b1;
    if (state == IDLE) snk_ready = any_elig | ~snk_sop;
  end

  // Malformed-input events; a stray sop on the forced-eop beat counts once.
  always_comb begin
    err_hit = 1'b0;
    case (state)
      IDLE:    err_hit = accept & ~snk_sop;
      BUSY:    err_hit = accept & (snk_sop | (~snk_eop & beat_last));
      default: err_hit = 1'b0;
    endcase
  end

  // Dispatch FSM with registered beat outputs and saturating error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      cur_core  <= '0;
      dst_data  <= '0;
      dst_we    <= '0;
      dst_sop   <= 1'b0;
      dst_eop   <= 1'b0;
      err_count <= '0;
    end else begin
      dst_we  <= '0;
      dst_sop <= 1'b0;
      dst_eop <= 1'b0;
      if (err_hit && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      case (state)
        IDLE: begin
          if (accept && snk_sop && sel_found) begin
            dst_data <= snk_data;
            dst_we   <= ONE << sel_core;
            dst_sop  <= 1'b1;
            dst_eop  <= snk_eop;
            cur_core <= 4'(sel_core);
            rr_ptr   <= rr_next;
            beat_cnt <= CNT_W'(1);
            state    <= snk_eop ? IDLE : BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            dst_data <= snk_data;
            dst_we   <= ONE << cur_core;
            beat_cnt <= beat_cnt + 1'b1;
            if (snk_eop) begin
              dst_eop <= 1'b1;
              state   <= IDLE;
            end else if (beat_last) begin
              dst_eop <= 1'b1;
              state   <= DROP;
            end
          end
        end
        DROP: begin
          if (accept && snk_eop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MSPE_DISPATCH_STATS_EN
  // Per-core wrapping count of packets started on that core.
  generate
    for (gi = 0; gi < CORES; gi++) begin : g_stat
      logic [31:0] pkt_cnt;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pkt_cnt <= '0;
        end else if (state == IDLE && accept && snk_sop && sel_found &&
                     sel_core == PTR_W'(gi)) begin
          pkt_cnt <= pkt_cnt + 32'd1;
        end
      end
      assign stat_pkts[gi*32 +: 32] = pkt_cnt;
    end
  endgenerate
`endif

endmodule
